mem_wb_skid_reg: RTL and testbench

Parametrised MEM/WB pipeline register with a valid/ready handshake and a 2-entry skid buffer. Back-pressure from write-back does not drop MEM-stage results.
Sits between the data-memory stage and register-file write-back. Adds a synchronous flush and a write-back data select (MemtoReg mux) with a write enable that is zero for Rd=0.

---
 rtl/mem_wb_pkg.sv | 21 ++
 rtl/pipe_skid2.sv | 73 +++++++
 rtl/mem_wb_skid_reg.sv | 96 +++++++++
 tb/tb_mem_wb_skid_reg.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared types and sizing helpers for the MEM/WB pipeline register.
//   state_t   : occupancy of the 2-entry skid buffer
//   XLEN_DEF  : default data-path width
//   REG_AW_DEF: default register-address width
//   payload_w : width of the packed MEM/WB payload {RegWrite, MemtoReg, mem, alu, rd}
package mem_wb_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   localparam int unsigned XLEN_DEF   = 64;
   localparam int unsigned REG_AW_DEF = 5;

   function automatic int unsigned payload_w(input int unsigned xlen, input int unsigned reg_aw);
      return 2 + 2 * xlen + reg_aw;
   endfunction

endpackage

// File: rtl/pipe_skid2.sv
// pipe_skid2: generic 2-entry skid buffer over a flat payload vector.
// The main entry drives the output; the skid entry catches the one extra item that
// arrives while the consumer stalls. in_ready depends only on registered state.
// Ports:
//   clk, reset (async, active-low), flush (sync squash of all held entries)
//   in_valid/in_ready/in_data   : producer side
//   out_valid/out_ready/out_data: consumer side (out_data = main entry)
module pipe_skid2
   import mem_wb_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   state_t       state_q;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         accept;
   logic         pop;

   assign in_ready  = (state_q != S_FULL);
   assign out_valid = (state_q != S_EMPTY);
   assign out_data  = main_q;
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Flush only clears occupancy; payload keeps stale contents and is masked downstream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (flush) begin
         state_q <= S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  main_q  <= in_data;
                  state_q <= S_ONE;
               end
            end
            S_ONE: begin
               if (accept && pop) begin
                  main_q <= in_data;
               end else if (accept) begin
                  skid_q  <= in_data;
                  state_q <= S_FULL;
               end else if (pop) begin
                  state_q <= S_EMPTY;
               end
            end
            S_FULL: begin
               if (pop) begin
                  main_q  <= skid_q;
                  state_q <= S_ONE;
               end
            end
            default: state_q <= S_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// mem_wb_skid_reg: MEM/WB pipeline register with valid/ready handshake and a 2-entry
// skid buffer, synchronous flush, MemtoReg write-back mux and Rd=0 write suppression.
// Optional statistics counters are built only when MEM_WB_STATS_EN is defined;
// otherwise stall_cnt/bubble_cnt are tied to 0.
// Ports:
//   clk, reset (async, active-low), flush
//   in_valid/in_ready, RegWrite, MemtoReg, Dataout_Memory, AluOut_in, Rd_in : MEM side
//   out_valid/out_ready, RegWrite_Out, MemtoReg_Out, DataOut, AluOut, Rd_out: WB side
//   wb_data, wb_en          : resolved write-back data and register-file write enable
//   stall_cnt, bubble_cnt   : stalled-cycle and empty-cycle counters
module mem_wb_skid_reg
   import mem_wb_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned REG_AW = REG_AW_DEF,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              RegWrite,
   input  logic              MemtoReg,
   input  logic [XLEN-1:0]   Dataout_Memory,
   input  logic [XLEN-1:0]   AluOut_in,
   input  logic [REG_AW-1:0] Rd_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              RegWrite_Out,
   output logic              MemtoReg_Out,
   output logic [XLEN-1:0]   DataOut,
   output logic [XLEN-1:0]   AluOut,
   output logic [REG_AW-1:0] Rd_out,
   output logic [XLEN-1:0]   wb_data,
   output logic              wb_en,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   localparam int unsigned PW = payload_w(XLEN, REG_AW);

   logic [PW-1:0] in_payload;
   logic [PW-1:0] head_payload;
   logic          head_regwrite;
   logic          head_memtoreg;

   assign in_payload = {RegWrite, MemtoReg, Dataout_Memory, AluOut_in, Rd_in};

   pipe_skid2 #(
      .W (PW)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_payload),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head_payload)
   );

   assign {head_regwrite, head_memtoreg, DataOut, AluOut, Rd_out} = head_payload;

   // Control bits are masked so stale payload after a flush can never cause a write.
   assign RegWrite_Out = head_regwrite & out_valid;
   assign MemtoReg_Out = head_memtoreg & out_valid;
   assign wb_data      = MemtoReg_Out ? DataOut : AluOut;
   assign wb_en        = out_valid & out_ready & RegWrite_Out & (Rd_out != '0);

`ifdef MEM_WB_STATS_EN
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] bubble_q;

   // Counters survive flush; they wrap naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (out_valid && !out_ready) stall_q <= stall_q + CntOne;
         if (!out_valid)              bubble_q <= bubble_q + CntOne;
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Scoreboard bench for mem_wb_skid_reg: the stimulus process pushes expected entries
// in issue order, a negedge monitor pops and compares on every output handshake.
module tb_mem_wb_skid_reg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 32;

   typedef struct {
      logic              rw;
      logic              m2r;
      logic [XLEN-1:0]   mem;
      logic [XLEN-1:0]   alu;
      logic [REG_AW-1:0] rd;
   } item_t;

   logic              clk;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic              RegWrite;
   logic              MemtoReg;
   logic [XLEN-1:0]   Dataout_Memory;
   logic [XLEN-1:0]   AluOut_in;
   logic [REG_AW-1:0] Rd_in;
   logic              out_valid;
   logic              out_ready;
   logic              RegWrite_Out;
   logic              MemtoReg_Out;
   logic [XLEN-1:0]   DataOut;
   logic [XLEN-1:0]   AluOut;
   logic [REG_AW-1:0] Rd_out;
   logic [XLEN-1:0]   wb_data;
   logic              wb_en;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   int    vectors;
   int    miscompares;
   item_t exp_q[$];
   item_t mon_e;

   mem_wb_skid_reg #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW),
      .CNT_W  (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .RegWrite       (RegWrite),
      .MemtoReg       (MemtoReg),
      .Dataout_Memory (Dataout_Memory),
      .AluOut_in      (AluOut_in),
      .Rd_in          (Rd_in),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .RegWrite_Out   (RegWrite_Out),
      .MemtoReg_Out   (MemtoReg_Out),
      .DataOut        (DataOut),
      .AluOut         (AluOut),
      .Rd_out         (Rd_out),
      .wb_data        (wb_data),
      .wb_en          (wb_en),
      .stall_cnt      (stall_cnt),
      .bubble_cnt     (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input item_t it);
      RegWrite       = it.rw;
      MemtoReg       = it.m2r;
      Dataout_Memory = it.mem;
      AluOut_in      = it.alu;
      Rd_in          = it.rd;
      in_valid       = 1'b1;
   endtask

   function automatic item_t mk(input logic rw, input logic m2r, input logic [63:0] mem,
                                input logic [63:0] alu, input logic [4:0] rd);
      item_t it;
      it.rw  = rw;
      it.m2r = m2r;
      it.mem = mem;
      it.alu = alu;
      it.rd  = rd;
      return it;
   endfunction

   // Monitor: every handshake on the output must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL pop_unexpected: got rd=%0d alu=%h expected no entry", Rd_out, AluOut);
         end else begin
            mon_e = exp_q.pop_front();
            if (RegWrite_Out !== mon_e.rw || MemtoReg_Out !== mon_e.m2r ||
                DataOut !== mon_e.mem || AluOut !== mon_e.alu || Rd_out !== mon_e.rd ||
                wb_data !== (mon_e.m2r ? mon_e.mem : mon_e.alu) ||
                wb_en !== (mon_e.rw && (mon_e.rd != 0))) begin
               miscompares++;
               $display("FAIL pop_entry: got rw=%b m2r=%b mem=%h alu=%h rd=%0d wb=%h en=%b expected rw=%b m2r=%b mem=%h alu=%h rd=%0d wb=%h en=%b",
                        RegWrite_Out, MemtoReg_Out, DataOut, AluOut, Rd_out, wb_data, wb_en,
                        mon_e.rw, mon_e.m2r, mon_e.mem, mon_e.alu, mon_e.rd,
                        mon_e.m2r ? mon_e.mem : mon_e.alu, mon_e.rw && (mon_e.rd != 0));
            end
         end
      end
   end

   initial begin
      item_t it;
      bit    got;
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      flush       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      RegWrite    = 1'b0;
      MemtoReg    = 1'b0;
      Dataout_Memory = '0;
      AluOut_in   = '0;
      Rd_in       = '0;
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_regwrite", 64'(RegWrite_Out), 64'd0);
      check("rst_wb_data", wb_data, 64'd0);
      check("rst_wb_en", 64'(wb_en), 64'd0);
      check("rst_rd_out", 64'(Rd_out), 64'd0);

      // Counters: 1 idle, 3 stalled, 1 pop, 1 idle, then a flush cycle (idle).
      @(negedge clk);
      reset = 1'b1;
      it = mk(1'b1, 1'b0, 64'h0, 64'h77, 5'd3);
      drive(it);
      exp_q.push_back(it);
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
`ifdef MEM_WB_STATS_EN
      check("cnt_stall", 64'(stall_cnt), 64'd3);
      check("cnt_bubble", 64'(bubble_cnt), 64'd2);
`else
      check("cnt_stall_off", 64'(stall_cnt), 64'd0);
      check("cnt_bubble_off", 64'(bubble_cnt), 64'd0);
`endif
      flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
`ifdef MEM_WB_STATS_EN
      check("cnt_stall_flush", 64'(stall_cnt), 64'd3);
      check("cnt_bubble_flush", 64'(bubble_cnt), 64'd3);
`else
      check("cnt_stall_flush_off", 64'(stall_cnt), 64'd0);
`endif

      // Single load through memory path.
      it = mk(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h0BAD, 5'd5);
      drive(it);
      exp_q.push_back(it);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("load_out_valid", 64'(out_valid), 64'd1);
      check("load_wb_data", wb_data, 64'hDEAD_BEEF_0000_0001);
      check("load_wb_en", 64'(wb_en), 64'd1);
      check("load_rd_out", 64'(Rd_out), 64'd5);

      // ALU path with Rd=0: pops but never writes.
      it = mk(1'b1, 1'b0, 64'h1111, 64'h42, 5'd0);
      drive(it);
      exp_q.push_back(it);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check("alu_out_valid", 64'(out_valid), 64'd1);
      check("alu_wb_data", wb_data, 64'h42);
      check("alu_wb_en", 64'(wb_en), 64'd0);

      // Back-pressure: A, B fill the buffer, C waits; drain must be A, B, C.
      @(negedge clk);
      out_ready = 1'b0;
      it = mk(1'b1, 1'b0, 64'hA0, 64'hA1, 5'd10);
      drive(it);
      exp_q.push_back(it);
      @(posedge clk); #1;
      it = mk(1'b1, 1'b1, 64'hB0, 64'hB1, 5'd11);
      drive(it);
      exp_q.push_back(it);
      @(negedge clk);
      check("bp_ready_one", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      it = mk(1'b0, 1'b0, 64'hC0, 64'hC1, 5'd12);
      drive(it);
      exp_q.push_back(it);
      @(negedge clk);
      check("bp_ready_full", 64'(in_ready), 64'd0);
      check("bp_head_alu", AluOut, 64'hA1);
      repeat (2) @(posedge clk);
      #1 out_ready = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      check("bp_c_accept", 64'(got), 64'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("bp_drain", 64'(exp_q.size()), 64'd0);

      // Flush in S_FULL with a same-cycle input: nothing survives.
      out_ready = 1'b0;
      drive(mk(1'b1, 1'b0, 64'hD0, 64'hD1, 5'd13));
      @(posedge clk); #1;
      drive(mk(1'b1, 1'b0, 64'hE0, 64'hE1, 5'd14));
      @(posedge clk); #1;
      drive(mk(1'b1, 1'b0, 64'hF0, 64'hF1, 5'd15));
      flush = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_regwrite", 64'(RegWrite_Out), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      check("flush_wb_en", 64'(wb_en), 64'd0);
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Async reset between edges with an entry held.
      out_ready = 1'b0;
      drive(mk(1'b1, 1'b1, 64'h5555_AAAA, 64'h1234, 5'd7));
      @(posedge clk); #1 in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("areset_out_valid", 64'(out_valid), 64'd0);
      check("areset_regwrite", 64'(RegWrite_Out), 64'd0);
      check("areset_memtoreg", 64'(MemtoReg_Out), 64'd0);
      check("areset_dataout", DataOut, 64'd0);
      check("areset_aluout", AluOut, 64'd0);
      check("areset_rd_out", 64'(Rd_out), 64'd0);
      check("areset_wb_data", wb_data, 64'd0);
      check("areset_in_ready", 64'(in_ready), 64'd1);
      check("areset_stall_cnt", 64'(stall_cnt), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // Traffic resumes normally after reset.
      out_ready = 1'b1;
      it = mk(1'b1, 1'b0, 64'h9, 64'h99, 5'd31);
      drive(it);
      exp_q.push_back(it);
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("final_drain", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
